// File: rtl/mod_mul_pipe.sv
// mod_mul_pipe: 3-stage pipelined Barrett modular multiplier, c = (a*b) mod q, q = Q0 or Q1 per op.
// Define MOD_MUL_PIPE_TAG_EN to add tag_i/tag_o and carry a TAG_W-bit tag alongside each op.
module mod_mul_pipe #(
   parameter int W  = 23,
   parameter int Q0 = 8380417,
   parameter int Q1 = 3329
`ifdef MOD_MUL_PIPE_TAG_EN
   ,
   parameter int TAG_W = 4
`endif
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [W-1:0]     a_i,
   input  logic [W-1:0]     b_i,
   input  logic             select_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [W-1:0]     c_o
`ifdef MOD_MUL_PIPE_TAG_EN
   ,
   input  logic [TAG_W-1:0] tag_i,
   output logic [TAG_W-1:0] tag_o
`endif
);

   localparam int PW = 2 * W;
   // (p >> (K-1)) < 2^(PW-K+1) and MU < 2^(K+1), so PW+2 bits hold the product exactly.
   localparam int XW = PW + 2;
   localparam int K0 = $clog2(Q0);
   localparam int K1 = $clog2(Q1);
   localparam logic [63:0] MU0 = (64'd1 << (2 * K0)) / 64'(Q0);
   localparam logic [63:0] MU1 = (64'd1 << (2 * K1)) / 64'(Q1);

   logic          s1_valid;
   logic [PW-1:0] s1_p;
   logic          s1_sel;
   logic          s2_valid;
   logic [PW-1:0] s2_p;
   logic [PW-1:0] s2_qh;
   logic          s2_sel;

   logic          s1_adv;
   logic          s2_adv;
   logic          s3_adv;

   // Handshake: a transfer happens on a rising edge where valid && ready are both high.
   // A stage loads when its register is empty or its contents move on this edge, so
   // bubbles collapse; ready_o depends combinationally on ready_i (no skid buffer).
   assign s3_adv  = !valid_o || ready_i;
   assign s2_adv  = !s2_valid || s3_adv;
   assign s1_adv  = !s1_valid || s2_adv;
   assign ready_o = s1_adv;

   // Stage 2 quotient estimate: qh = ((p >> (K-1)) * MU) >> (K+1), never exceeds p/q.
   int            k_s1;
   logic [XW-1:0] mu_s1;
   logic [XW-1:0] qh_full;

   always_comb begin
      if (s1_sel) begin
         k_s1  = K1;
         mu_s1 = XW'(MU1);
      end else begin
         k_s1  = K0;
         mu_s1 = XW'(MU0);
      end
      qh_full = ((XW'(s1_p) >> (k_s1 - 1)) * mu_s1) >> (k_s1 + 1);
   end

   // Stage 3: qh*q <= p, so the PW-bit difference is exact; r0 < 3q needs two corrections.
   logic [PW-1:0] q_s2;
   logic [PW-1:0] r0;
   logic [PW-1:0] r1;
   logic [PW-1:0] r2;

   always_comb begin
      q_s2 = s2_sel ? PW'(Q1) : PW'(Q0);
      r0   = s2_p - s2_qh * q_s2;
      r1   = (r0 >= q_s2) ? r0 - q_s2 : r0;
      r2   = (r1 >= q_s2) ? r1 - q_s2 : r1;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         s1_valid <= 1'b0;
         s1_p     <= '0;
         s1_sel   <= 1'b0;
      end else if (s1_adv) begin
         s1_valid <= valid_i;
         if (valid_i) begin
            s1_p   <= PW'(a_i) * PW'(b_i);
            s1_sel <= select_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         s2_valid <= 1'b0;
         s2_p     <= '0;
         s2_qh    <= '0;
         s2_sel   <= 1'b0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_p   <= s1_p;
            s2_qh  <= PW'(qh_full);
            s2_sel <= s1_sel;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         valid_o <= 1'b0;
         c_o     <= '0;
      end else if (s3_adv) begin
         valid_o <= s2_valid;
         if (s2_valid) begin
            c_o <= W'(r2);
         end
      end
   end

`ifdef MOD_MUL_PIPE_TAG_EN
   logic [TAG_W-1:0] s1_tag;
   logic [TAG_W-1:0] s2_tag;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         s1_tag <= '0;
         s2_tag <= '0;
         tag_o  <= '0;
      end else begin
         if (s1_adv && valid_i) begin
            s1_tag <= tag_i;
         end
         if (s2_adv && s1_valid) begin
            s2_tag <= s1_tag;
         end
         if (s3_adv && s2_valid) begin
            tag_o <= s2_tag;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mod_mul_pipe.sv
// tb_mod_mul_pipe: randomized bench for mod_mul_pipe with a plain (a*b)%q reference model.
// Build with MOD_MUL_PIPE_TAG_EN defined to also check tag transport.
module tb_mod_mul_pipe;
   localparam int W = 23;
   localparam int TAG_W = 4;
   localparam int unsigned Q0 = 8380417;
   localparam int unsigned Q1 = 3329;

   logic         clk;
   logic         rst_n_i;
   logic         valid_i;
   logic         ready_o;
   logic [W-1:0] a_i;
   logic [W-1:0] b_i;
   logic         select_i;
   logic         valid_o;
   logic         ready_i;
   logic [W-1:0] c_o;
`ifdef MOD_MUL_PIPE_TAG_EN
   logic [TAG_W-1:0] tag_i;
   logic [TAG_W-1:0] tag_o;
   logic [TAG_W-1:0] tag_ctr;
   logic [TAG_W-1:0] exp_tag_q[$];
   logic [TAG_W-1:0] got_tag_q[$];
`endif

   int n_checks;
   int n_errors;
   int cyc;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] got_q[$];
   int           got_cyc_q[$];

   mod_mul_pipe dut (
      .clk_i    (clk),
      .rst_n_i  (rst_n_i),
      .valid_i  (valid_i),
      .ready_o  (ready_o),
      .a_i      (a_i),
      .b_i      (b_i),
      .select_i (select_i),
      .valid_o  (valid_o),
      .ready_i  (ready_i),
      .c_o      (c_o)
`ifdef MOD_MUL_PIPE_TAG_EN
      ,
      .tag_i    (tag_i),
      .tag_o    (tag_o)
`endif
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   // reference model: straight from the definition
   function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sel);
      longint q;
      longint p;
      q = sel ? longint'(Q1) : longint'(Q0);
      p = longint'(a) * longint'(b);
      return W'(p % q);
   endfunction

   function automatic logic [W-1:0] rand_operand(input logic sel);
      return W'(sel ? $urandom_range(0, Q1 - 1) : $urandom_range(0, Q0 - 1));
   endfunction

   // scoreboard: expectations pushed on accepted inputs, observations on accepted outputs
   always @(negedge clk) begin
      if (rst_n_i) begin
         if (valid_i && ready_o) begin
            exp_q.push_back(model(a_i, b_i, select_i));
`ifdef MOD_MUL_PIPE_TAG_EN
            exp_tag_q.push_back(tag_i);
`endif
         end
         if (valid_o && ready_i) begin
            got_q.push_back(c_o);
            got_cyc_q.push_back(cyc);
`ifdef MOD_MUL_PIPE_TAG_EN
            got_tag_q.push_back(tag_o);
`endif
         end
      end
   end

   // driver tasks
   task automatic clear_queues();
      exp_q.delete();
      got_q.delete();
      got_cyc_q.delete();
`ifdef MOD_MUL_PIPE_TAG_EN
      exp_tag_q.delete();
      got_tag_q.delete();
`endif
   endtask

   task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sel);
      int budget;
      a_i      = a;
      b_i      = b;
      select_i = sel;
      valid_i  = 1'b1;
`ifdef MOD_MUL_PIPE_TAG_EN
      tag_i   = tag_ctr;
      tag_ctr = tag_ctr + 1'b1;
`endif
      budget = 0;
      @(negedge clk);
      while (!ready_o && budget < 100) begin
         @(negedge clk);
         budget++;
      end
      n_checks++;
      if (ready_o !== 1'b1) begin
         n_errors++;
         $display("FAIL accept_timeout: ready_o=%b after %0d cycles, required 1", ready_o, budget);
      end
      @(posedge clk);
      #1;
      valid_i = 1'b0;
   endtask

   task automatic drain(input int n);
      int budget;
      budget = 0;
      while (got_q.size() < n && budget < 300) begin
         @(posedge clk);
         budget++;
      end
      repeat (4) @(posedge clk);
      #1;
   endtask

   // tests
   task automatic test_reset();
      @(negedge clk);
      n_checks++;
      if (valid_o !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_valid_o: got %b expected 0", valid_o);
      end
      n_checks++;
      if (c_o !== '0) begin
         n_errors++;
         $display("FAIL reset_c_o: got %0d expected 0", c_o);
      end
      n_checks++;
      if (ready_o !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_ready_o: got %b expected 1", ready_o);
      end
`ifdef MOD_MUL_PIPE_TAG_EN
      n_checks++;
      if (tag_o !== '0) begin
         n_errors++;
         $display("FAIL reset_tag_o: got %0d expected 0", tag_o);
      end
`endif
      @(posedge clk);
      #1;
   endtask

   task automatic test_vectors();
      int unsigned va[6] = '{3328, 1234, 0, Q0 - 1, 3328, 5};
      int unsigned vb[6] = '{3328, 1, 3000, 2, 3327, 7};
      logic        vs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      int unsigned vc[6] = '{1, 1234, 0, Q0 - 2, 2, 35};
      clear_queues();
      ready_i  = 1'b1;
      a_i      = W'(Q0 - 1);
      b_i      = W'(Q0 - 1);
      select_i = 1'b0;
      valid_i  = 1'b1;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      @(negedge clk);
      n_checks++;
      if (valid_o !== 1'b0) begin
         n_errors++;
         $display("FAIL latency_edge1: valid_o got %b expected 0", valid_o);
      end
      @(negedge clk);
      n_checks++;
      if (valid_o !== 1'b0) begin
         n_errors++;
         $display("FAIL latency_edge2: valid_o got %b expected 0", valid_o);
      end
      @(negedge clk);
      n_checks++;
      if (valid_o !== 1'b1 || c_o !== W'(1)) begin
         n_errors++;
         $display("FAIL latency_edge3: valid_o=%b c_o=%0d expected valid_o=1 c_o=1", valid_o, c_o);
      end
      @(posedge clk);
      #1;
      drain(0);
      clear_queues();
      for (int i = 0; i < 6; i++) drive_op(W'(va[i]), W'(vb[i]), vs[i]);
      drain(6);
      n_checks++;
      if (got_q.size() != 6) begin
         n_errors++;
         $display("FAIL vec_count: got %0d results expected 6", got_q.size());
      end
      for (int i = 0; i < 6 && i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== W'(vc[i])) begin
            n_errors++;
            $display("FAIL vec[%0d]: c_o got %0d expected %0d", i, got_q[i], vc[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int   n;
      int   t0;
      logic sel;
      n = 1000;
      clear_queues();
      ready_i = 1'b1;
      t0 = cyc;
      for (int i = 0; i < n; i++) begin
         sel = i[0];
         drive_op(rand_operand(sel), rand_operand(sel), sel);
      end
      n_checks++;
      if (cyc - t0 != n) begin
         n_errors++;
         $display("FAIL b2b_input_rate: %0d cycles for %0d ops, expected %0d", cyc - t0, n, n);
      end
      drain(n);
      n_checks++;
      if (got_q.size() != n || exp_q.size() != n) begin
         n_errors++;
         $display("FAIL b2b_count: got %0d results (%0d accepted) expected %0d", got_q.size(), exp_q.size(), n);
      end
      n_checks++;
      if (got_cyc_q.size() == n && got_cyc_q[n-1] - got_cyc_q[0] != n - 1) begin
         n_errors++;
         $display("FAIL b2b_output_rate: results spanned %0d cycles expected %0d", got_cyc_q[n-1] - got_cyc_q[0], n - 1);
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i]) begin
            n_errors++;
            $display("FAIL b2b_data[%0d]: c_o got %0d expected %0d", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      int           acc;
      int           unstable;
      logic         held;
      logic         took;
      logic [W-1:0] c_hold;
      logic         sel;
      clear_queues();
      acc      = 0;
      unstable = 0;
      held     = 1'b0;
      c_hold   = '0;
      ready_i  = 1'b0;
      sel      = 1'($urandom_range(0, 1));
      a_i      = rand_operand(sel);
      b_i      = rand_operand(sel);
      select_i = sel;
      valid_i  = 1'b1;
      for (int cy = 0; cy < 6; cy++) begin
         @(negedge clk);
         if (valid_o) begin
            if (!held) begin
               held   = 1'b1;
               c_hold = c_o;
            end else if (c_o !== c_hold) begin
               unstable++;
            end
         end
         took = ready_o;
         @(posedge clk);
         #1;
         if (took) begin
            acc++;
            sel      = 1'($urandom_range(0, 1));
            a_i      = rand_operand(sel);
            b_i      = rand_operand(sel);
            select_i = sel;
         end
      end
      @(negedge clk);
      n_checks++;
      if (acc != 3) begin
         n_errors++;
         $display("FAIL stall_accepts: accepted %0d ops while stalled expected 3", acc);
      end
      n_checks++;
      if (ready_o !== 1'b0) begin
         n_errors++;
         $display("FAIL stall_ready_o: got %b expected 0", ready_o);
      end
      n_checks++;
      if (valid_o !== 1'b1 || c_o !== c_hold || unstable != 0) begin
         n_errors++;
         $display("FAIL stall_hold: valid_o=%b c_o=%0d held=%0d changes=%0d expected 1/%0d/0",
                  valid_o, c_o, c_hold, unstable, c_hold);
      end
      n_checks++;
      if (got_q.size() != 0) begin
         n_errors++;
         $display("FAIL stall_no_output: got %0d results expected 0", got_q.size());
      end
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      ready_i = 1'b1;
      drain(3);
      n_checks++;
      if (got_q.size() != 3) begin
         n_errors++;
         $display("FAIL stall_count: got %0d results expected 3", got_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i]) begin
            n_errors++;
            $display("FAIL stall_data[%0d]: c_o got %0d expected %0d", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_random_stalls();
      int   n;
      logic done;
      logic sel;
      n    = 200;
      done = 1'b0;
      clear_queues();
      fork
         begin
            for (int i = 0; i < n; i++) begin
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end
               sel = 1'($urandom_range(0, 1));
               drive_op(rand_operand(sel), rand_operand(sel), sel);
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               ready_i = 1'($urandom_range(0, 1));
            end
         end
      join
      ready_i = 1'b1;
      drain(n);
      n_checks++;
      if (got_q.size() != n || exp_q.size() != n) begin
         n_errors++;
         $display("FAIL rand_count: got %0d results (%0d accepted) expected %0d", got_q.size(), exp_q.size(), n);
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i]) begin
            n_errors++;
            $display("FAIL rand_data[%0d]: c_o got %0d expected %0d", i, got_q[i], exp_q[i]);
         end
      end
`ifdef MOD_MUL_PIPE_TAG_EN
      for (int i = 0; i < got_tag_q.size() && i < exp_tag_q.size(); i++) begin
         n_checks++;
         if (got_tag_q[i] !== exp_tag_q[i]) begin
            n_errors++;
            $display("FAIL rand_tag[%0d]: tag_o got %0d expected %0d", i, got_tag_q[i], exp_tag_q[i]);
         end
      end
`endif
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] a;
      logic [W-1:0] b;
      clear_queues();
      ready_i = 1'b0;
      drive_op(rand_operand(1'b0), rand_operand(1'b0), 1'b0);
      drive_op(rand_operand(1'b1), rand_operand(1'b1), 1'b1);
      @(posedge clk);
      #1;
      @(negedge clk);
      n_checks++;
      if (valid_o !== 1'b1) begin
         n_errors++;
         $display("FAIL rstmid_pre: valid_o got %b expected 1", valid_o);
      end
      #2;
      rst_n_i = 1'b0;
      #1;
      n_checks++;
      if (valid_o !== 1'b0 || c_o !== '0) begin
         n_errors++;
         $display("FAIL rstmid_async: valid_o=%b c_o=%0d expected 0/0", valid_o, c_o);
      end
      clear_queues();
      ready_i = 1'b1;
      @(posedge clk);
      #1;
      rst_n_i = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      n_checks++;
      if (got_q.size() != 0 || valid_o !== 1'b0) begin
         n_errors++;
         $display("FAIL rstmid_stale: %0d results, valid_o=%b expected none/0", got_q.size(), valid_o);
      end
      a = rand_operand(1'b1);
      b = rand_operand(1'b1);
      drive_op(a, b, 1'b1);
      drain(1);
      n_checks++;
      if (got_q.size() != 1 || got_q[0] !== model(a, b, 1'b1)) begin
         n_errors++;
         $display("FAIL rstmid_new: %0d results, first c_o=%0d expected 1 result c_o=%0d",
                  got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, model(a, b, 1'b1));
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n_i  = 1'b0;
      valid_i  = 1'b0;
      ready_i  = 1'b1;
      a_i      = '0;
      b_i      = '0;
      select_i = 1'b0;
`ifdef MOD_MUL_PIPE_TAG_EN
      tag_i   = '0;
      tag_ctr = '0;
`endif
      repeat (3) @(posedge clk);
      #1;
      rst_n_i = 1'b1;
      test_reset();
      test_vectors();
      test_back_to_back();
      test_backpressure();
      test_random_stalls();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
